// File: rtl/conv3x3_window_engine_if.sv
// Signal bundle tying the 3x3 window engine to its image RAMs, conv weight RAM and result sink.
// The engine side uses the slave modport; the RAM/consumer environment uses master.
interface conv3x3_window_engine_if #(
    parameter int ACC_W = 20
);
    logic                    i_start;
    logic [15:0]             i_kern_base;
    logic [13:0]             o_img_addr;
    logic [7:0]              i_img_q0;
    logic [7:0]              i_img_q1;
    logic [7:0]              i_img_q2;
    logic [7:0]              i_img_q3;
    logic [15:0]             o_w_addr;
    logic [7:0]              i_w_q;
    logic                    o_out_valid;
    logic                    i_out_ready;
    logic signed [ACC_W-1:0] o_out_data;
    logic [9:0]              o_out_idx;
    logic                    o_busy;
    logic                    o_done;

    modport slave (
        input  i_start, i_kern_base,
        input  i_img_q0, i_img_q1, i_img_q2, i_img_q3, i_w_q,
        input  i_out_ready,
        output o_img_addr, o_w_addr,
        output o_out_valid, o_out_data, o_out_idx, o_busy, o_done
    );

    modport master (
        output i_start, i_kern_base,
        output i_img_q0, i_img_q1, i_img_q2, i_img_q3, i_w_q,
        output i_out_ready,
        input  o_img_addr, o_w_addr,
        input  o_out_valid, o_out_data, o_out_idx, o_busy, o_done
    );
endinterface

// File: rtl/conv3x3_window_engine.sv
// Slides one 3x3 kernel (bias + nine weights) over a square image held in four interleaved byte
// RAMs and streams the valid-convolution feature map out in row-major order.
module conv3x3_window_engine #(
    parameter int IMG_W = 28,
    parameter int ACC_W = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    conv3x3_window_engine_if.slave bus
);

    localparam int OUT_W = IMG_W - 2;
    localparam int PIX_W = $clog2(IMG_W * IMG_W);
    localparam int POS_W = $clog2(IMG_W);

    localparam logic [3:0]       LOAD_LAST  = 4'd10;
    localparam logic [3:0]       FETCH_LAST = 4'd9;
    localparam logic [POS_W-1:0] POS_LAST   = POS_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StFetch,
        StEmit,
        StDone
    } state_e;

    state_e                  r_state;
    state_e                  w_state_nxt;
    logic [3:0]              r_cnt;
    logic [15:0]             r_kern_base;
    logic [POS_W-1:0]        r_row;
    logic [POS_W-1:0]        r_col;
    logic [9:0]              r_idx;
    logic [1:0]              r_lane;
    logic signed [7:0]       r_bias;
    logic signed [7:0]       r_w [9];
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_busy;
    logic                    w_done;
    logic                    w_valid;
    logic                    w_last_pos;
    logic                    w_issue_img;
    logic                    w_issue_w;
    logic [1:0]              w_dr;
    logic [1:0]              w_dc;
    logic [PIX_W-1:0]        w_pix_idx;
    logic [7:0]              w_pix;
    logic [3:0]              w_widx;
    logic signed [7:0]       w_wsel;
    logic signed [16:0]      w_prod;

    assign w_last_pos  = (r_row == POS_LAST) && (r_col == POS_LAST);
    assign w_issue_img = (r_state == StFetch) && (r_cnt < FETCH_LAST);
    assign w_issue_w   = (r_state == StLoadW) && (r_cnt < LOAD_LAST);

    // Tap offset within the window for the read issued this FETCH cycle.
    always_comb begin
        w_dr = 2'd0;
        w_dc = 2'd0;
        case (r_cnt)
            4'd1: w_dc = 2'd1;
            4'd2: w_dc = 2'd2;
            4'd3: w_dr = 2'd1;
            4'd4: begin w_dr = 2'd1; w_dc = 2'd1; end
            4'd5: begin w_dr = 2'd1; w_dc = 2'd2; end
            4'd6: w_dr = 2'd2;
            4'd7: begin w_dr = 2'd2; w_dc = 2'd1; end
            4'd8: begin w_dr = 2'd2; w_dc = 2'd2; end
            default: ;
        endcase
    end

    assign w_pix_idx = PIX_W'((32'(r_row) + 32'(w_dr)) * 32'(IMG_W) + 32'(r_col) + 32'(w_dc));

    assign bus.o_img_addr = w_issue_img ? 14'(w_pix_idx >> 2) : 14'd0;
    assign bus.o_w_addr   = w_issue_w ? (r_kern_base + 16'(r_cnt)) : 16'd0;

    always_comb begin
        w_pix = bus.i_img_q0;
        unique case (r_lane)
            2'd0: w_pix = bus.i_img_q0;
            2'd1: w_pix = bus.i_img_q1;
            2'd2: w_pix = bus.i_img_q2;
            2'd3: w_pix = bus.i_img_q3;
        endcase
    end

    // Data returning at count k belongs to the tap issued at k-1.
    assign w_widx = r_cnt - 4'd1;
    assign w_wsel = r_w[w_widx];
    assign w_prod = $signed({1'b0, w_pix}) * w_wsel;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_valid     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.i_start) w_state_nxt = StLoadW;
            end
            StLoadW: begin
                w_busy = 1'b1;
                if (r_cnt == LOAD_LAST) w_state_nxt = StFetch;
            end
            StFetch: begin
                w_busy = 1'b1;
                if (r_cnt == FETCH_LAST) w_state_nxt = StEmit;
            end
            StEmit: begin
                w_busy  = 1'b1;
                w_valid = 1'b1;
                if (bus.i_out_ready) w_state_nxt = w_last_pos ? StDone : StFetch;
            end
            StDone: begin
                w_done      = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= 4'd0;
            r_kern_base <= 16'd0;
            r_row       <= '0;
            r_col       <= '0;
            r_idx       <= 10'd0;
            r_lane      <= 2'd0;
            r_bias      <= 8'sd0;
            r_acc       <= '0;
            for (int k = 0; k < 9; k++) r_w[k] <= 8'sd0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.i_start) begin
                        r_kern_base <= bus.i_kern_base;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_idx       <= 10'd0;
                        r_cnt       <= 4'd0;
                    end
                end
                StLoadW: begin
                    r_cnt <= (r_cnt == LOAD_LAST) ? 4'd0 : r_cnt + 4'd1;
                    // Count 1 returns the bias, counts 2..10 return w0..w8.
                    if (r_cnt == 4'd1) begin
                        r_bias <= bus.i_w_q;
                    end else if (r_cnt != 4'd0) begin
                        r_w[r_cnt - 4'd2] <= bus.i_w_q;
                    end
                end
                StFetch: begin
                    r_cnt  <= (r_cnt == FETCH_LAST) ? 4'd0 : r_cnt + 4'd1;
                    r_lane <= w_pix_idx[1:0];
                    if (r_cnt == 4'd0) begin
                        r_acc <= ACC_W'(r_bias);
                    end else begin
                        r_acc <= r_acc + ACC_W'(w_prod);
                    end
                end
                StEmit: begin
                    if (bus.i_out_ready) begin
                        r_idx <= r_idx + 10'd1;
                        if (r_col == POS_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_out_valid = w_valid;
    assign bus.o_out_data  = r_acc;
    assign bus.o_out_idx   = r_idx;
    assign bus.o_busy      = w_busy;
    assign bus.o_done      = w_done;

endmodule

// File: doc/conv3x3_window_engine.md
# conv3x3_window_engine

Downstream consumer of the image/weight loader. After the loader fills the four interleaved image RAMs and the conv weight RAM, this block reads one 3x3 kernel (bias plus nine weights) and slides it over the 28x28 image. It produces the 26x26 valid-convolution feature map in row-major order, one result at a time, over a valid/ready stream. It owns the read ports of the image RAMs and the conv weight RAM while busy.

## Interface
- IMG_W, 28, image width/height in pixels (square)
- ACC_W, 20, accumulator/output width (signed)
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- kern_base  in  16  conv RAM address of this kernel's bias byte; sampled on accepted start
- img_addr  out  14  shared address to image RAMs 0-3
- img_q0, img_q1, img_q2, img_q3  in  8 each  image RAM read data (unsigned pixels), 1-cycle latency
- w_addr  out  16  conv weight RAM address
- w_q  in  8  conv RAM read data (signed), 1-cycle latency
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts when high with out_valid
- out_data  out  ACC_W  signed convolution result
- out_idx  out  10  result position r*26+c
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last result accepted

## Operation
- Pixel p = r*28+c is stored in image RAM p[1:0] at address p>>2.
  - The lane is selected by p[1:0], registered alongside the issued address.
- Kernel layout in conv RAM:
  - bias at kern_base
  - weight k = dr*3+dc at kern_base+1+k
  - all values signed 8-bit
- FSM states: IDLE, LOAD_W, FETCH, EMIT, DONE.
- IDLE -> LOAD_W on start. Latch kern_base; clear r, c, out_idx.
- LOAD_W issues 10 reads in 10 consecutive cycles (bias, then w0..w8) and captures each value the cycle after its read. After 11 cycles: LOAD_W -> FETCH.
- FETCH handles one output position (r,c):
  - issues 9 pixel reads, taps (dr,dc) in row-major order, one per cycle
  - seeds the accumulator with the sign-extended bias
  - adds zero-extended pixel times signed weight as each pixel returns
  - after the last product (10 cycles): FETCH -> EMIT
- EMIT holds out_valid, out_data and out_idx stable until out_ready.
  - On the handshake, advance c (wrap 25->0, r+1).
  - If (r,c) was (25,25): EMIT -> DONE. Otherwise EMIT -> FETCH.
- DONE pulses done for 1 cycle, then returns to IDLE.
- Arithmetic: 9x255x128 + 128 fits in 20 signed bits; no saturation, no ReLU.
- start is ignored while busy. kern_base changes after start are ignored.
- img_addr and w_addr are don't-care in IDLE/DONE; drive 0.

## Timing
- Reset values: out_valid=0, out_data=0, out_idx=0, busy=0, done=0, img_addr=0, w_addr=0, state=IDLE.
- Reset has priority over everything, including mid-run and mid-handshake.
  - All outputs return to reset values next cycle.
  - Partial results are discarded.
- busy rises the cycle after the accepted start.
- First out_valid appears 11+10 = 21 cycles after busy rises.
- Per result: 10 FETCH cycles + 1 EMIT cycle minimum with out_ready held high. A full run is 11 + 676x11 = 7447 cycles to the last handshake, then done the next cycle. busy falls with done.
- out_ready high while out_valid is low has no effect. out_valid never drops without a handshake or reset.
- start asserted in the same cycle as done is ignored. start is accepted in IDLE only.

## Test plan
- Image all 1s, weights all 1, bias 0, out_ready=1 -> 676 results, each 9; out_idx 0..675 in order; done pulse exactly once, 7448 cycles after start.
- Image pixel p = p mod 256, weight w4=1, others 0, bias -5 -> out_data at (r,c) = ((r+1)*28+c+1) mod 256 - 5; covers all four RAM lanes.
- Image all 255, weights all -128, bias -128 -> every out_data = -293888; no overflow in 20 bits.
- out_ready toggled randomly -> out_data/out_idx stable while valid and not ready; no result lost or duplicated; sequence matches the reference model.
- reset asserted during result 100's EMIT -> all outputs 0 next cycle. A fresh start then reproduces the full sequence from out_idx 0.
- Second start pulses during a run -> ignored; exactly 676 results and one done. A new start after done begins a second run using the new kern_base.
